// File: rtl/par_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package par_divider_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/par_divider_seq_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial
// remainder, with restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic             borrow;
    logic [WIDTH-1:0] diff;

    assign borrow = partial < {1'b0, divisor};
    // On no borrow the true difference is below the divisor, so the low WIDTH bits are exact.
    assign diff     = partial[WIDTH-1:0] - divisor;
    assign rem_next = borrow ? partial[WIDTH-1:0] : diff;
    assign q_bit    = ~borrow;

endmodule

// File: rtl/par_divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Define PAR_DIVIDER_ZERO_FAST_EN to complete divide-by-zero in a single cycle.
module par_divider_seq
    import par_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             q_bit;

    assign partial  = {rem_q, dvd_q[WIDTH-1]};
    assign quo_next = {quo_q[WIDTH-2:0], q_bit};

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .partial (partial),
        .divisor (dvs_q),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        rem_q <= '0;
                        quo_q <= '0;
                        cnt_q <= CntW'(WIDTH - 1);
`ifdef PAR_DIVIDER_ZERO_FAST_EN
                        if (divisor == '0) begin
                            state_q   <= StDone;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            dz        <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                        end
`else
                        state_q <= StRun;
                        busy    <= 1'b1;
`endif
                    end
                end
                StRun: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_next;
                        remainder <= rem_next;
                        dz        <= (dvs_q == '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_par_divider_seq.sv
// Self-checking bench for par_divider_seq (WIDTH=8) against an arithmetic reference model.
module tb_par_divider_seq;

    localparam int W = 8;
`ifdef PAR_DIVIDER_ZERO_FAST_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    par_divider_seq #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz)
    );

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Scramble the inputs to show the operands were captured.
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1 && exp_lat > 1) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                check({tag, " done low"}, 32'(done), 32'd0);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           lat;
        model(a, b, eq, er);
        launch(a, b);
        wait_done(tag, (b == 0) ? ZeroLat : W + 1, lat);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " dz"}, 32'(dz), 32'(b == 0));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " quotient hold"}, 32'(quotient), 32'(eq));
        check({tag, " remainder hold"}, 32'(remainder), 32'(er));
    endtask

    initial begin
        int           lat;
        int           done_cnt;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dz", 32'(dz), 32'd0);
        rst_n = 1'b1;

        do_div("200/7", 8'd200, 8'd7);
        do_div("5/9", 8'd5, 8'd9);
        do_div("255/1", 8'd255, 8'd1);
        do_div("77/0", 8'd77, 8'd0);

        // Start held high through RUN with changing operands, then back-to-back on done.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            dividend = W'($urandom);
            divisor  = W'($urandom);
        end
        check("100/3 latency", lat, W + 1);
        check("100/3 quotient", 32'(quotient), 32'd33);
        check("100/3 remainder", 32'(remainder), 32'd1);
        check("100/3 dz", 32'(dz), 32'd0);
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        wait_done("50/5", W + 1, lat);
        check("50/5 quotient", 32'(quotient), 32'd10);
        check("50/5 remainder", 32'(remainder), 32'd0);

        // Reset in the fourth RUN cycle aborts the division.
        launch(8'd200, 8'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        check("abort dz", 32'(dz), 32'd0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort no done", done_cnt, 0);

        // Reset and start at the same edge: reset wins; start right after release.
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(negedge clk);
        check("reset wins busy", 32'(busy), 32'd0);
        check("reset wins done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        wait_done("9/2", W + 1, lat);
        check("9/2 quotient", 32'(quotient), 32'd4);
        check("9/2 remainder", 32'(remainder), 32'd1);

        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            do_div($sformatf("rand%0d %0d/%0d", i, a, b), a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
